// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: steps one weight store through every phase of a layer and presents each vector to the MAC array
module weight_fetch_ctrl #(
    parameter int N_PHASE_MAX = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3:0]                     layer,
    input  logic [3:0]                     num_phase,
    input  logic                           abort,
    input  logic                           store_valid,
    input  logic                           w_take,
    output logic                           load,
    output logic [3:0]                     cs,
    output logic [$clog2(N_PHASE_MAX)-1:0] phase,
    output logic                           w_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    typedef enum logic [2:0] {IDLE, GAP, FETCH, HOLD, FIN} state_t;
    state_t     state;
    logic [3:0] n;
    logic [3:0] cnt;
    logic [3:0] n_clamp;
    logic       last;
    assign n_clamp = (num_phase == 4'd0 || num_phase > 4'(N_PHASE_MAX)) ? 4'(N_PHASE_MAX) : num_phase;
    assign last    = 4'(phase) == n - 4'd1;
    // Sequencer: a cnt of 0 marks the first FETCH cycle, where the store's valid is still stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n       <= 4'd0;
            cnt     <= 4'd0;
            load    <= 1'b0;
            cs      <= 4'd0;
            phase   <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (abort && state != IDLE) begin
            state   <= IDLE;
            load    <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cs    <= layer;
                    n     <= n_clamp;
                    phase <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= GAP;
                end
                GAP: begin
                    load  <= 1'b1;
                    cnt   <= 4'd0;
                    state <= FETCH;
                end
                FETCH: if (store_valid && cnt != 4'd0) begin
                    w_valid <= 1'b1;
                    state   <= HOLD;
                end else if (cnt == 4'(TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    load  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                HOLD: if (w_take) begin
                    load    <= 1'b0;
                    w_valid <= 1'b0;
                    if (last) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        phase <= phase + 1'b1;
                        state <= GAP;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
